// File: rtl/apb_serial_switch_mp_pkg.sv
// Shared definitions for the APB serial packet switch: register byte offsets,
// CTRL/STATUS bit positions and TX state encodings.
package apb_serial_switch_mp_pkg;

  localparam logic [31:0] ADDR_CTRL    = 32'h0000_0000;
  localparam logic [31:0] ADDR_CHIP_ID = 32'h0000_0004;
  localparam logic [31:0] ADDR_PORT_EN = 32'h0000_0008;
  localparam logic [31:0] ADDR_PKT_CNT = 32'h0000_000C;
  localparam logic [31:0] ADDR_STATUS  = 32'h0000_0010;

  localparam int CTRL_CHIP_EN = 0;
  localparam int CTRL_SWAP_EN = 1;

  localparam int ST_RX_BUSY  = 0;
  localparam int ST_TX_BUSY  = 1;
  localparam int ST_HOLD_VLD = 2;
  localparam int ST_DROP     = 3;

  localparam logic [0:0] TX_IDLE = 1'b0;
  localparam logic [0:0] TX_SEND = 1'b1;

endpackage

// File: rtl/apb_serial_switch_mp_if.sv
// Bus bundle for the switch: APB register access plus the serial ingress and
// multicast egress streams.
//   master : drives APB request, serial input and out_ready
//   slave  : the switch; returns prdata, out_port, valid_out
interface apb_serial_switch_mp_if #(
  parameter int NUM_PORTS = 4
);
  logic [31:0]          paddr;
  logic                 psel;
  logic                 pen;
  logic                 p_write;
  logic [31:0]          p_wdata;
  logic [31:0]          prdata;
  logic                 data_in;
  logic                 valid_in;
  logic                 out_ready;
  logic [NUM_PORTS-1:0] out_port;
  logic                 valid_out;

  modport master (
    output paddr, psel, pen, p_write, p_wdata, data_in, valid_in, out_ready,
    input  prdata, out_port, valid_out
  );

  modport slave (
    input  paddr, psel, pen, p_write, p_wdata, data_in, valid_in, out_ready,
    output prdata, out_port, valid_out
  );
endinterface

// File: rtl/apb_serial_switch_mp_serial_rx_deser.sv
// Serial-to-parallel packet deserialiser.
//   clk, rst (async, active-low), en (chip enable), data_in/valid_in (MSB first)
//   rx_sr : shift register, holds the full packet in the cycle done is high
//   done  : one-cycle pulse after the PKT_W-th bit has been shifted in
//   busy  : a partial packet is in progress
module serial_rx_deser #(
  parameter int PKT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             data_in,
  input  logic             valid_in,
  output logic [PKT_W-1:0] rx_sr,
  output logic             done,
  output logic             busy
);
  localparam int CW = $clog2(PKT_W);

  logic [CW-1:0] rx_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sr  <= '0;
      rx_cnt <= '0;
      done   <= 1'b0;
    end else if (!en) begin
      // disabling drops any partial packet
      rx_cnt <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (valid_in) begin
        rx_sr <= {rx_sr[PKT_W-2:0], data_in};
        if (rx_cnt == CW'(PKT_W-1)) begin
          rx_cnt <= '0;
          done   <= 1'b1;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end
    end
  end

  assign busy = (rx_cnt != '0);

endmodule

// File: rtl/apb_serial_switch_mp.sv
// Serial packet switch with APB register bank, one-deep holding buffer,
// optional dest/src swap and multicast re-serialisation.
//   clk, rst (async, active-low)
//   bus (slave): APB paddr/psel/pen/p_write/p_wdata -> prdata (registered),
//                data_in/valid_in in, out_ready in, out_port/valid_out out
//
// TX FSM
//   state   | meaning
//   TX_IDLE | nothing presented; loads tx_sr when the holding buffer is full
//   TX_SEND | packet presented; shifts one bit per cycle with out_ready
module apb_serial_switch_mp
  import apb_serial_switch_mp_pkg::*;
#(
  parameter int         PKT_W     = 64,
  parameter int         ADDR_W    = 16,
  parameter int         NUM_PORTS = 4,
  parameter logic [7:0] CHIP_ID   = 8'hAA,
  parameter int         CNT_W     = 16
) (
  input logic                   clk,
  input logic                   rst,
  apb_serial_switch_mp_if.slave bus
);
  localparam int TW = $clog2(PKT_W + 1);

  logic                 chip_en, swap_en, drop;
  logic [NUM_PORTS-1:0] port_en, tx_mask;
  logic [CNT_W-1:0]     pkt_cnt;
  logic [PKT_W-1:0]     rx_sr, rx_pkt, hold_buf, tx_sr;
  logic                 rx_done, rx_busy, hold_vld;
  logic [0:0]           tx_state;
  logic [TW-1:0]        tx_left;
  logic [31:0]          prdata_q, rd_val;
  logic [3:0]           status_v;
  logic                 wr_en, rd_en, tx_last, tx_load, valid_out;

  serial_rx_deser #(.PKT_W(PKT_W)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .en       (chip_en),
    .data_in  (bus.data_in),
    .valid_in (bus.valid_in),
    .rx_sr    (rx_sr),
    .done     (rx_done),
    .busy     (rx_busy)
  );

  assign wr_en = bus.psel & bus.pen & bus.p_write;
  assign rd_en = bus.psel & bus.pen & ~bus.p_write;

  // tx_left counts down remaining bits; the last accepted bit ends the packet
  assign tx_last = (tx_state == TX_SEND) & bus.out_ready & (tx_left == TW'(1));
  assign tx_load = hold_vld & ((tx_state == TX_IDLE) | tx_last);

  always_comb begin
    rx_pkt = rx_sr;
    if (swap_en) begin
      rx_pkt[PKT_W-1 -: ADDR_W]        = rx_sr[PKT_W-ADDR_W-1 -: ADDR_W];
      rx_pkt[PKT_W-ADDR_W-1 -: ADDR_W] = rx_sr[PKT_W-1 -: ADDR_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chip_en <= 1'b1;
      swap_en <= 1'b1;
      port_en <= NUM_PORTS'(1);
      pkt_cnt <= '0;
      drop    <= 1'b0;
    end else begin
      if (wr_en && bus.paddr == ADDR_CTRL) begin
        chip_en <= bus.p_wdata[CTRL_CHIP_EN];
        swap_en <= bus.p_wdata[CTRL_SWAP_EN];
      end
      if (wr_en && bus.paddr == ADDR_PORT_EN)
        port_en <= bus.p_wdata[NUM_PORTS-1:0];
      if (wr_en && bus.paddr == ADDR_PKT_CNT)
        pkt_cnt <= '0;
      else if (tx_last)
        pkt_cnt <= pkt_cnt + 1'b1;
      // a fresh overflow wins over a same-cycle clear so no event is lost
      if (rx_done && hold_vld && !tx_load)
        drop <= 1'b1;
      else if (wr_en && bus.paddr == ADDR_STATUS && bus.p_wdata[ST_DROP])
        drop <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_buf <= '0;
      hold_vld <= 1'b0;
      tx_sr    <= '0;
      tx_mask  <= '0;
      tx_left  <= '0;
      tx_state <= TX_IDLE;
    end else begin
      if (tx_load) begin
        tx_sr    <= hold_buf;
        tx_mask  <= port_en;
        tx_left  <= TW'(PKT_W);
        tx_state <= TX_SEND;
      end else if (tx_state == TX_SEND && bus.out_ready) begin
        tx_sr   <= tx_sr << 1;
        tx_left <= tx_left - 1'b1;
        if (tx_left == TW'(1))
          tx_state <= TX_IDLE;
      end
      // buffer refills on the same edge it drains
      if (rx_done && (!hold_vld || tx_load)) begin
        hold_buf <= rx_pkt;
        hold_vld <= 1'b1;
      end else if (tx_load) begin
        hold_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    status_v              = '0;
    status_v[ST_RX_BUSY]  = rx_busy;
    status_v[ST_TX_BUSY]  = (tx_state == TX_SEND);
    status_v[ST_HOLD_VLD] = hold_vld;
    status_v[ST_DROP]     = drop;
    case (bus.paddr)
      ADDR_CTRL:    rd_val = {30'b0, swap_en, chip_en};
      ADDR_CHIP_ID: rd_val = 32'(CHIP_ID);
      ADDR_PORT_EN: rd_val = 32'(port_en);
      ADDR_PKT_CNT: rd_val = 32'(pkt_cnt);
      ADDR_STATUS:  rd_val = {28'b0, status_v};
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      prdata_q <= '0;
    else if (rd_en)
      prdata_q <= rd_val;
  end

  assign valid_out    = (tx_state == TX_SEND);
  assign bus.prdata   = prdata_q;
  assign bus.valid_out = valid_out;
  assign bus.out_port = tx_mask & {NUM_PORTS{valid_out & tx_sr[PKT_W-1] & chip_en}};

endmodule
